// File: rtl/fifo_cu_pkg.sv
// Shared types and defaults for the FIFO control unit.
// Holds the default error-counter width and the status-flag bundle sampled from the datapath.
package fifo_cu_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  // Status flags from the FIFO datapath, one bit each.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic push_err;
    logic pop_err;
  } cu_status_t;

endpackage

// File: rtl/cu_err_track.sv
// Sticky error flag plus a saturating error counter.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   err    - error event for this cycle
//   clr    - clears the flag and counter; wins over err
//   sticky - latched error indicator
//   cnt    - saturating count of error cycles
module cu_err_track #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err,
  input  logic             clr,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Flag and counter; clear takes priority so a simultaneous error is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (clr) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (err) begin
      sticky <= 1'b1;
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/top_cu.sv
// Control unit for the FIFO datapath.
// Converts status and error flags into registered write/read enables and tracks errors.
// Ports:
//   clk_cu, rst_n_in_cu         - clock and synchronous active-low reset
//   full_cu, empty_cu           - FIFO full / empty
//   almost_full_cu/_empty_cu    - FIFO almost flags (used only when USE_ALMOST=1)
//   push_on_full_error_cu       - write attempted while full
//   pop_on_empty_error_cu       - read attempted while empty
//   err_clr_cu                  - clears sticky flags and counters
//   wt_en_cu, rd_en_cu          - registered enables to the datapath
//   push/pop_err_sticky_cu      - latched error flags
//   push/pop_err_cnt_cu         - saturating error counts
module top_cu
  import fifo_cu_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned USE_ALMOST = 0
) (
  input  logic             clk_cu,
  input  logic             rst_n_in_cu,
  input  logic             full_cu,
  input  logic             empty_cu,
  input  logic             almost_full_cu,
  input  logic             almost_empty_cu,
  input  logic             push_on_full_error_cu,
  input  logic             pop_on_empty_error_cu,
  input  logic             err_clr_cu,
  output logic             wt_en_cu,
  output logic             rd_en_cu,
  output logic             push_err_sticky_cu,
  output logic             pop_err_sticky_cu,
  output logic [CNT_W-1:0] push_err_cnt_cu,
  output logic [CNT_W-1:0] pop_err_cnt_cu
);

  cu_status_t st;
  logic       wt_tog;
  logic       rd_tog;
  logic       wt_tog_nxt;
  logic       rd_tog_nxt;
  logic       wt_en_nxt;
  logic       rd_en_nxt;

  assign st = '{full:         full_cu,
                empty:        empty_cu,
                almost_full:  almost_full_cu,
                almost_empty: almost_empty_cu,
                push_err:     push_on_full_error_cu,
                pop_err:      pop_on_empty_error_cu};

  // Next enables; an asserted almost flag passes the enable only when its toggle is set.
  always_comb begin
    wt_en_nxt  = ~st.full & ~st.push_err;
    rd_en_nxt  = ~st.empty & ~st.pop_err;
    wt_tog_nxt = 1'b0;
    rd_tog_nxt = 1'b0;
    if (USE_ALMOST != 0) begin
      if (st.almost_full) begin
        wt_en_nxt  = wt_en_nxt & wt_tog;
        wt_tog_nxt = ~wt_tog;
      end
      if (st.almost_empty) begin
        rd_en_nxt  = rd_en_nxt & rd_tog;
        rd_tog_nxt = ~rd_tog;
      end
    end
  end

  // Enable and toggle registers.
  always_ff @(posedge clk_cu) begin
    if (!rst_n_in_cu) begin
      wt_en_cu <= 1'b0;
      rd_en_cu <= 1'b0;
      wt_tog   <= 1'b0;
      rd_tog   <= 1'b0;
    end else begin
      wt_en_cu <= wt_en_nxt;
      rd_en_cu <= rd_en_nxt;
      wt_tog   <= wt_tog_nxt;
      rd_tog   <= rd_tog_nxt;
    end
  end

  cu_err_track #(.CNT_W(CNT_W)) u_push_err (
    .clk    (clk_cu),
    .rst_n  (rst_n_in_cu),
    .err    (st.push_err),
    .clr    (err_clr_cu),
    .sticky (push_err_sticky_cu),
    .cnt    (push_err_cnt_cu)
  );

  cu_err_track #(.CNT_W(CNT_W)) u_pop_err (
    .clk    (clk_cu),
    .rst_n  (rst_n_in_cu),
    .err    (st.pop_err),
    .clr    (err_clr_cu),
    .sticky (pop_err_sticky_cu),
    .cnt    (pop_err_cnt_cu)
  );

endmodule

// File: tb/tb_top_cu.sv
// Directed bench for top_cu: one instance with CNT_W=2/USE_ALMOST=0, one with CNT_W=8/USE_ALMOST=1,
// driven by the same inputs.
module tb_top_cu;

  logic clk = 1'b0;
  logic rst_n, full, empty, afull, aempty, push_err, pop_err, clr;

  logic       wt0, rd0, pss0, pps0;
  logic [1:0] pc0, oc0;
  logic       wt1, rd1, pss1, pps1;
  logic [7:0] pc1, oc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  top_cu #(.CNT_W(2), .USE_ALMOST(0)) dut0 (
    .clk_cu(clk), .rst_n_in_cu(rst_n), .full_cu(full), .empty_cu(empty),
    .almost_full_cu(afull), .almost_empty_cu(aempty),
    .push_on_full_error_cu(push_err), .pop_on_empty_error_cu(pop_err),
    .err_clr_cu(clr), .wt_en_cu(wt0), .rd_en_cu(rd0),
    .push_err_sticky_cu(pss0), .pop_err_sticky_cu(pps0),
    .push_err_cnt_cu(pc0), .pop_err_cnt_cu(oc0)
  );

  top_cu #(.CNT_W(8), .USE_ALMOST(1)) dut1 (
    .clk_cu(clk), .rst_n_in_cu(rst_n), .full_cu(full), .empty_cu(empty),
    .almost_full_cu(afull), .almost_empty_cu(aempty),
    .push_on_full_error_cu(push_err), .pop_on_empty_error_cu(pop_err),
    .err_clr_cu(clr), .wt_en_cu(wt1), .rd_en_cu(rd1),
    .push_err_sticky_cu(pss1), .pop_err_sticky_cu(pps1),
    .push_err_cnt_cu(pc1), .pop_err_cnt_cu(oc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] v);
    {full, push_err, empty, pop_err} = v;
  endtask

  task automatic chk_en(input string tag, input logic w, input logic r);
    chk({tag, "_wt0"}, 32'(wt0), 32'(w));
    chk({tag, "_rd0"}, 32'(rd0), 32'(r));
    chk({tag, "_wt1"}, 32'(wt1), 32'(w));
    chk({tag, "_rd1"}, 32'(rd1), 32'(r));
  endtask

  task automatic chk_err(input string tag, input logic ps, input logic [7:0] pc_e0,
                         input logic [7:0] pc_e1, input logic os, input logic [7:0] oc_e0,
                         input logic [7:0] oc_e1);
    chk({tag, "_push_sticky0"}, 32'(pss0), 32'(ps));
    chk({tag, "_push_cnt0"},    32'(pc0),  32'(pc_e0));
    chk({tag, "_push_sticky1"}, 32'(pss1), 32'(ps));
    chk({tag, "_push_cnt1"},    32'(pc1),  32'(pc_e1));
    chk({tag, "_pop_sticky0"},  32'(pps0), 32'(os));
    chk({tag, "_pop_cnt0"},     32'(oc0),  32'(oc_e0));
    chk({tag, "_pop_sticky1"},  32'(pps1), 32'(os));
    chk({tag, "_pop_cnt1"},     32'(oc1),  32'(oc_e1));
  endtask

  logic [3:0] tt_in  [9];
  logic [1:0] tt_out [9];
  logic       alt_exp [6];

  initial begin
    tt_in  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010};
    tt_out = '{2'b11,   2'b10,   2'b10,   2'b01,   2'b00,   2'b00,   2'b01,   2'b00,   2'b00};
    alt_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held two edges with errors pulsed: everything stays cleared.
    rst_n = 1'b0; full = 1'b0; empty = 1'b0; afull = 1'b0; aempty = 1'b0;
    push_err = 1'b1; pop_err = 1'b1; clr = 1'b0;
    tick();
    push_err = 1'b0; pop_err = 1'b0;
    tick();
    chk_en("reset", 1'b0, 1'b0);
    chk_err("reset", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);

    // Release with all flags low: both enables rise one edge later.
    rst_n = 1'b1;
    tick();
    chk_en("release", 1'b1, 1'b1);

    // Input change is not visible before the next edge.
    full = 1'b1;
    #2;
    chk("no_comb_path_wt0", 32'(wt0), 32'd1);
    full = 1'b0;

    // Enable truth table, one vector per cycle.
    for (int i = 0; i < 9; i++) begin
      set_flags(tt_in[i]);
      tick();
      chk_en($sformatf("tt%0d", i), tt_out[i][1], tt_out[i][0]);
    end
    // Three push errors and three pop errors were applied: CNT_W=2 sits at max.
    set_flags(4'b0000);
    chk_err("tt_errs", 1'b1, 8'd3, 8'd3, 1'b1, 8'd3, 8'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_err("clr1", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    chk_en("clr1_en", 1'b1, 1'b1);

    // Read-side activity leaves the write enable alone.
    for (int i = 0; i < 4; i++) begin
      empty   = i[0];
      pop_err = i[1];
      tick();
      chk(($sformatf("indep%0d_wt0", i)), 32'(wt0), 32'd1);
      chk(($sformatf("indep%0d_rd0", i)), 32'(rd0), 32'(i == 0));
    end
    empty = 1'b0; pop_err = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_err("clr2", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);

    // Five push errors: 2-bit counter saturates at 3, 8-bit counter reaches 5.
    push_err = 1'b1;
    tick();
    chk_err("sat1", 1'b1, 8'd1, 8'd1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) tick();
    push_err = 1'b0;
    chk_err("sat5", 1'b1, 8'd3, 8'd5, 1'b0, 8'd0, 8'd0);
    chk_en("sat5_en", 1'b0, 1'b1);
    tick();
    chk_err("sat_hold", 1'b1, 8'd3, 8'd5, 1'b0, 8'd0, 8'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_err("sat_clr", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);

    // Clear beats a simultaneous error; clear does not touch the enables.
    pop_err = 1'b1;
    tick();
    chk_err("pop1", 1'b0, 8'd0, 8'd0, 1'b1, 8'd1, 8'd1);
    clr = 1'b1;
    tick();
    chk_err("clr_vs_err", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    chk_en("clr_vs_err_en", 1'b1, 1'b0);
    clr = 1'b0; pop_err = 1'b0;
    tick();
    chk_en("post_clr_en", 1'b1, 1'b1);

    // Almost-full alternation on the USE_ALMOST=1 instance only.
    afull = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("afull%0d_wt1", i), 32'(wt1), 32'(alt_exp[i]));
      chk($sformatf("afull%0d_wt0", i), 32'(wt0), 32'd1);
      chk($sformatf("afull%0d_rd1", i), 32'(rd1), 32'd1);
    end
    afull = 1'b0;
    tick();
    chk("afull_off_wt1", 32'(wt1), 32'd1);

    // Almost-empty alternation, toggle restarts from 0 on each new assertion.
    aempty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("aempty%0d_rd1", i), 32'(rd1), 32'(alt_exp[i]));
      chk($sformatf("aempty%0d_rd0", i), 32'(rd0), 32'd1);
      chk($sformatf("aempty%0d_wt1", i), 32'(wt1), 32'd1);
    end
    aempty = 1'b0;
    tick();
    aempty = 1'b1;
    tick();
    chk("aempty_restart_rd1", 32'(rd1), 32'd0);
    aempty = 1'b0;

    // Mid-operation reset overrides live errors.
    push_err = 1'b1; pop_err = 1'b1;
    tick();
    rst_n = 1'b0;
    push_err = 1'b1; pop_err = 1'b1;
    tick();
    chk_en("midreset", 1'b0, 1'b0);
    chk_err("midreset", 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    rst_n = 1'b1; push_err = 1'b0; pop_err = 1'b0;
    tick();
    chk_en("midreset_rel", 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
